// File: rtl/bcd_result_converter.sv
// bcd_result_converter: converts the mini ALU's unsigned binary result into packed
// BCD digits using iterative double-dabble (add-3 then shift, one bit per clock).
// A start/busy/done handshake frames each conversion. bcd_out and overflow hold the
// last converted value until the next conversion completes.
// Optional build macro BCD_SEG7_EN adds seg_n, the registered active-low gfedcba
// seven-segment pattern for each displayed digit.
module bcd_result_converter #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
`ifdef BCD_SEG7_EN
    ,
    output logic [7*DIGITS-1:0]   seg_n
`endif
);

    // Scratch keeps one extra digit above the displayed ones so that values of
    // 10^DIGITS and above can be flagged rather than silently wrapped.
    localparam int SCR_W = 4 * (DIGITS + 1);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SCR_W-1:0]    scr_q, scr_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic [SCR_W-2:0]    adj;
    logic                top_nz;

    // Add 3 to every scratch digit that is 5 or more. The MSB of the top digit is
    // shifted out on the following shift, so only the remaining bits are returned.
    function automatic logic [SCR_W-2:0] dabble_adjust(input logic [SCR_W-1:0] s);
        logic [SCR_W-2:0] r;
        logic [3:0]       top;
        r = s[SCR_W-2:0];
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end
        end
        top = s[SCR_W-1 -: 4];
        if (top >= 4'd5) begin
            r[SCR_W-2 -: 3] = 3'(top + 4'd3);
        end
        return r;
    endfunction

`ifdef BCD_SEG7_EN
    logic [7*DIGITS-1:0] seg_q, seg_d;

    // Active-low gfedcba pattern for one BCD digit; non-decimal codes blank.
    function automatic logic [6:0] seg7_encode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction
`endif

    assign adj    = dabble_adjust(scr_q);
    assign top_nz = |scr_q[SCR_W-1 -: 4];

    // Next-state and datapath computation for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d = state_q;
        scr_d   = scr_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
`ifdef BCD_SEG7_EN
        seg_d   = seg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    scr_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scr_d = {adj, bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // busy drops as DONE is entered so busy and done never overlap.
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = scr_q[4*DIGITS-1:0];
                ovf_d   = top_nz;
                done_d  = 1'b1;
                state_d = ST_IDLE;
`ifdef BCD_SEG7_EN
                for (int i = 0; i < DIGITS; i++) begin
                    seg_d[7*i +: 7] = top_nz ? 7'h3F : seg7_encode(scr_q[4*i +: 4]);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            scr_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef BCD_SEG7_EN
            seg_q   <= {DIGITS{7'h7F}};
`endif
        end else begin
            state_q <= state_d;
            scr_q   <= scr_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
`ifdef BCD_SEG7_EN
            seg_q   <= seg_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;
`ifdef BCD_SEG7_EN
    assign seg_n    = seg_q;
`endif

endmodule
